// File: rtl/md_sequencer_pkg.sv
// Shared op codes, default latencies and ID-stage decode helpers for the MD sequencer.
// MD_SEQUENCER_MADD_EN widens md_op and adds the madd/msub accumulate ops.
package md_sequencer_pkg;

`ifdef MD_SEQUENCER_MADD_EN
    localparam int unsigned MD_OP_W = 4;
`else
    localparam int unsigned MD_OP_W = 3;
`endif

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;
    localparam logic [3:0] MD_MSUB  = 4'd8;
    localparam logic [3:0] MD_MSUBU = 4'd9;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    // MIPS encodings used by ID to flag MD-class instructions
    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1c;
    localparam logic [5:0] FN_MFHI      = 6'h10;
    localparam logic [5:0] FN_MTHI      = 6'h11;
    localparam logic [5:0] FN_MFLO      = 6'h12;
    localparam logic [5:0] FN_MTLO      = 6'h13;
    localparam logic [5:0] FN_MULT      = 6'h18;
    localparam logic [5:0] FN_DIVU      = 6'h1b;
    localparam logic [5:0] FN2_MADD     = 6'h00;
    localparam logic [5:0] FN2_MADDU    = 6'h01;
    localparam logic [5:0] FN2_MSUB     = 6'h04;
    localparam logic [5:0] FN2_MSUBU    = 6'h05;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } md_result_t;

    function automatic logic id_is_md_class(input logic [5:0] opcode, input logic [5:0] funct);
        logic hit;
        hit = (opcode == OPC_SPECIAL) &&
              ((funct >= FN_MFHI && funct <= FN_MTLO) || (funct >= FN_MULT && funct <= FN_DIVU));
`ifdef MD_SEQUENCER_MADD_EN
        hit = hit || ((opcode == OPC_SPECIAL2) &&
              (funct == FN2_MADD || funct == FN2_MADDU || funct == FN2_MSUB || funct == FN2_MSUBU));
`endif
        return hit;
    endfunction

    // Ops that occupy the unit for a multi-cycle latency
    function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
        logic [3:0] o;
        o = 4'(op);
`ifdef MD_SEQUENCER_MADD_EN
        return (o <= MD_DIVU) || (o >= MD_MADD && o <= MD_MSUBU);
`else
        return (o <= MD_DIVU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (4'(op) == MD_DIV) || (4'(op) == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; valid=0 flags a divide by zero.
// Accumulate ops exist only with MD_SEQUENCER_MADD_EN.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [31:0]        hi,
    input  logic [31:0]        lo,
    output logic [63:0]        result,
    output logic               valid
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_nz;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    // Divisor forced non-zero so the divider never produces X; valid masks the result
    always_comb begin
        prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        prod_u = {32'd0, a} * {32'd0, b};
        b_nz   = (b == 32'd0) ? 32'd1 : b;
        quot_s = 32'($signed(a) / $signed(b_nz));
        rem_s  = 32'($signed(a) % $signed(b_nz));
        quot_u = a / b_nz;
        rem_u  = a % b_nz;
    end

    always_comb begin
        result = 64'd0;
        valid  = 1'b0;
        case (4'(op))
            MD_MULT:  begin result = prod_s;         valid = 1'b1;         end
            MD_MULTU: begin result = prod_u;         valid = 1'b1;         end
            MD_DIV:   begin result = {rem_s, quot_s}; valid = (b != 32'd0); end
            MD_DIVU:  begin result = {rem_u, quot_u}; valid = (b != 32'd0); end
`ifdef MD_SEQUENCER_MADD_EN
            MD_MADD:  begin result = {hi, lo} + prod_s; valid = 1'b1; end
            MD_MADDU: begin result = {hi, lo} + prod_u; valid = 1'b1; end
            MD_MSUB:  begin result = {hi, lo} - prod_s; valid = 1'b1; end
            MD_MSUBU: begin result = {hi, lo} - prod_u; valid = 1'b1; end
`endif
            default:  begin result = 64'd0; valid = 1'b0; end
        endcase
    end

`ifndef MD_SEQUENCER_MADD_EN
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MIPS multiply/divide sequencer with HI/LO registers and ID stall request.
// Optional accumulate ops are enabled with MD_SEQUENCER_MADD_EN.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               md_start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        md_a,
    input  logic [31:0]        md_b,
    input  logic               id_is_md,
    output logic               busy,
    output logic               stall_req,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_result_t         pend_q, pend_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [63:0]        ar_result;
    logic               ar_valid;

    md_arith u_arith (
        .op     (md_op),
        .a      (md_a),
        .b      (md_b),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (ar_result),
        .valid  (ar_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Issue, countdown and commit; requests outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    if (is_long_op(md_op)) begin
                        pend_d.valid = ar_valid;
                        pend_d.data  = ar_result;
                        cnt_d        = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy_d       = 1'b1;
                        state_d      = ST_RUN;
                    end else if (4'(md_op) == MD_MTHI) begin
                        hi_d = md_a;
                    end else if (4'(md_op) == MD_MTLO) begin
                        lo_d = md_a;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_q.valid) begin
                        hi_d = pend_q.data[63:32];
                        lo_d = pend_q.data[31:0];
                    end
                    pend_d  = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = id_is_md & (busy_q | (md_start & is_long_op(md_op)));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer (covers MD_SEQUENCER_MADD_EN when defined).
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               md_start;
    logic [MD_OP_W-1:0] md_op;
    logic [31:0]        md_a, md_b;
    logic               id_is_md;
    logic               busy, stall_req;
    logic [31:0]        hi, lo;

    int checks = 0;
    int errors = 0;
    int n_busy, n_stall;
    logic stall_at_issue;

    md_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_a      (md_a),
        .md_b      (md_b),
        .id_is_md  (id_is_md),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request at the current negedge; returns at the next negedge
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1;
        md_op    = MD_OP_W'(op);
        md_a     = a;
        md_b     = b;
        #1 stall_at_issue = stall_req;
        @(negedge clk);
        md_start = 1'b0;
    endtask

    // Count busy (and stalled) cycles until busy drops, bounded
    task automatic measure();
        n_busy  = 0;
        n_stall = 0;
        while (busy === 1'b1 && n_busy < 100) begin
            n_busy++;
            if (stall_req === 1'b1) n_stall++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; md_start = 1'b0; md_op = '0; md_a = '0; md_b = '0; id_is_md = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // mult signed with stall coverage
        do_op(MD_MULT, 32'hFFFFFFFF, 32'h00000002);
        chk("mult_stall_issue", 64'(stall_at_issue), 64'd1);
        measure();
        chk("mult_busy_cycles", 64'(n_busy), 64'd5);
        chk("mult_stall_cycles", 64'(n_stall), 64'd5);
        chk("mult_stall_after", 64'(stall_req), 64'd0);
        chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo), 64'hFFFFFFFE);

        // multu, no MD instruction in ID so no stall
        id_is_md = 1'b0;
        do_op(MD_MULTU, 32'hFFFFFFFF, 32'h00000002);
        chk("multu_stall_issue", 64'(stall_at_issue), 64'd0);
        measure();
        chk("multu_busy_cycles", 64'(n_busy), 64'd5);
        chk("multu_hi", 64'(hi), 64'h00000001);
        chk("multu_lo", 64'(lo), 64'hFFFFFFFE);

        // div -7 / 2
        do_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        measure();
        chk("div_busy_cycles", 64'(n_busy), 64'd10);
        chk("div_hi", 64'(hi), 64'hFFFFFFFF);
        chk("div_lo", 64'(lo), 64'hFFFFFFFD);

        // divu by zero keeps hi/lo
        do_op(MD_DIVU, 32'd7, 32'd0);
        measure();
        chk("div0_busy_cycles", 64'(n_busy), 64'd10);
        chk("div0_hi", 64'(hi), 64'hFFFFFFFF);
        chk("div0_lo", 64'(lo), 64'hFFFFFFFD);

        // mtlo / mthi
        do_op(MD_MTLO, 32'h00001234, 32'd0);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_lo", 64'(lo), 64'h00001234);
        chk("mtlo_hi_kept", 64'(hi), 64'hFFFFFFFF);
        do_op(MD_MTHI, 32'h0000ABCD, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h0000ABCD);
        chk("mthi_lo_kept", 64'(lo), 64'h00001234);

        // back-to-back: mult, then div issued the first idle cycle, with an illegal start mid-div
        do_op(MD_MULT, 32'd3, 32'd4);
        measure();
        chk("b2b_mult_busy", 64'(n_busy), 64'd5);
        chk("b2b_mult_lo", 64'(lo), 64'd12);
        do_op(MD_DIV, 32'd100, 32'd7);
        chk("b2b_div_busy", 64'(busy), 64'd1);
        do_op(MD_MULT, 32'd5, 32'd5);
        measure();
        chk("b2b_div_busy_cycles", 64'(n_busy + 1), 64'd10);
        chk("b2b_div_hi", 64'(hi), 64'd2);
        chk("b2b_div_lo", 64'(lo), 64'd14);

`ifdef MD_SEQUENCER_MADD_EN
        do_op(MD_MTHI, 32'd0, 32'd0);
        do_op(MD_MTLO, 32'h10, 32'd0);
        do_op(MD_MADD, 32'd3, 32'hFFFFFFFE);
        measure();
        chk("madd_busy_cycles", 64'(n_busy), 64'd5);
        chk("madd_hi", 64'(hi), 64'd0);
        chk("madd_lo", 64'(lo), 64'h0000000A);
`else
        do_op(MD_MADD, 32'd3, 32'hFFFFFFFE);
        chk("madd_ignored_busy", 64'(busy), 64'd0);
        chk("madd_ignored_hi", 64'(hi), 64'd2);
        chk("madd_ignored_lo", 64'(lo), 64'd14);
`endif

        // reset in the middle of a divide discards the pending result
        do_op(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_after_busy", 64'(busy), 64'd0);
        chk("rst_after_hi", 64'(hi), 64'd0);
        chk("rst_after_lo", 64'(lo), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
